cpu4_exec_ctrl: RTL and testbench

Fetch/execute controller for the 4-bit CPU: it fetches 10-bit instructions over a request/acknowledge port, decodes them, and drives the ALU (operands A/B and 2-bit OP). It captures the ALU result and its CF/SF/ZF outputs into the register file and a flags register, then sequences the PC, including conditional jumps on the stored flags. It is the initiator side of the ALU interface; the ALU stays a separate purely combinational instance wired beside it at CPU top level.

---
 rtl/cpu4_pkg.sv | 34 +++
 rtl/cpu4_regfile.sv | 32 +++
 rtl/cpu4_exec_ctrl.sv | 137 +++++++++++++
 tb/tb_cpu4_exec_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU: opcodes, ALU op codes, controller states
// and instruction field positions.
package cpu4_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_JC  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [1:0] ALU_CMP = 2'b00;
  localparam logic [1:0] ALU_ROL = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int OP_MSB  = 9;
  localparam int OP_LSB  = 7;
  localparam int RD_MSB  = 6;
  localparam int RD_LSB  = 5;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/cpu4_regfile.sv
// Four 4-bit registers: two combinational read ports, one write port on the
// rising edge, cleared asynchronously by reset.
module cpu4_regfile
  import cpu4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  rd_addr_i,
  input  logic [1:0]  rs_addr_i,
  output logic [3:0]  rd_data_o,
  output logic [3:0]  rs_data_o,
  input  logic        we_i,
  input  logic [1:0]  wr_addr_i,
  input  logic [3:0]  wr_data_i,
  output logic [15:0] dump_o
);

  logic [3:0][3:0] regs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (we_i) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = regs_q[rd_addr_i];
  assign rs_data_o = regs_q[rs_addr_i];
  assign dump_o    = regs_q;

endmodule

// File: rtl/cpu4_exec_ctrl.sv
// Fetch/execute controller: fetches over req/ack, drives the external
// combinational ALU in EXEC and commits result, flags and PC at the end of EXEC.
module cpu4_exec_ctrl
  import cpu4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [3:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [9:0]  imem_data,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [1:0]  alu_op,
  input  logic [3:0]  alu_r,
  input  logic        alu_cf,
  input  logic        alu_sf,
  input  logic        alu_zf,
  output logic [2:0]  flags,
  output logic [3:0]  pc,
  output logic        halted,
  output logic [15:0] reg_dump
);

  state_t      state_q;
  logic [3:0]  pc_q, pc_d;
  logic [9:0]  ir_q;
  logic [2:0]  flags_q;
  logic        req_q;
  logic        halted_q;

  logic [2:0]  op;
  logic [1:0]  rd, rs;
  logic [3:0]  imm;
  logic [3:0]  rd_val, rs_val;
  logic        in_exec, is_alu, rf_we;
  logic [3:0]  rf_wdata;
  logic        unused_ir;

  assign op        = ir_q[OP_MSB:OP_LSB];
  assign rd        = ir_q[RD_MSB:RD_LSB];
  assign rs        = ir_q[RS_MSB:RS_LSB];
  assign imm       = ir_q[IMM_MSB:IMM_LSB];
  assign unused_ir = ir_q[4];

  assign in_exec = (state_q == ST_EXEC);
  assign is_alu  = (op == OP_ADD) || (op == OP_CMP) || (op == OP_ROL);

  cpu4_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_i (rd),
    .rs_addr_i (rs),
    .rd_data_o (rd_val),
    .rs_data_o (rs_val),
    .we_i      (rf_we),
    .wr_addr_i (rd),
    .wr_data_i (rf_wdata),
    .dump_o    (reg_dump)
  );

  // ALU sees the idle pattern (ADD of zeros) unless an ALU op is executing.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = 4'd0;
    alu_b  = 4'd0;
    if (in_exec && is_alu) begin
      alu_a = rd_val;
      alu_b = rs_val;
      case (op)
        OP_CMP:  alu_op = ALU_CMP;
        OP_ROL:  alu_op = ALU_ROL;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  assign rf_we    = in_exec && ((op == OP_LDI) || (op == OP_ADD) || (op == OP_ROL));
  assign rf_wdata = (op == OP_LDI) ? imm : alu_r;

  // Jumps test the stored flags: {CF,SF,ZF}.
  always_comb begin
    pc_d = pc_q + 4'd1;
    case (op)
      OP_JZ:   if (flags_q[0]) pc_d = imm;
      OP_JC:   if (flags_q[2]) pc_d = imm;
      OP_HLT:  pc_d = pc_q;
      default: pc_d = pc_q + 4'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      pc_q     <= 4'd0;
      ir_q     <= 10'd0;
      flags_q  <= 3'b000;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_data;
            state_q <= ST_EXEC;
            req_q   <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (is_alu) flags_q <= {alu_cf, alu_sf, alu_zf};
          pc_q <= pc_d;
          if (op == OP_HLT) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign flags     = flags_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu4_exec_ctrl.sv
// Bench for cpu4_exec_ctrl: external ALU, instruction memory with wait states,
// and an instruction-level reference model of the CPU.
module tb_cpu4_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [3:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [9:0]  imem_data = 10'd0;
  logic [3:0]  alu_a, alu_b, alu_r;
  logic [1:0]  alu_op;
  logic        alu_cf, alu_sf, alu_zf;
  logic [2:0]  flags;
  logic [3:0]  pc;
  logic        halted;
  logic [15:0] reg_dump;

  int checks = 0;
  int errors = 0;

  logic [9:0] mem [16];

  int m_r [4];
  int m_pc, m_cf, m_sf, m_zf;
  bit m_halt;

  always #5 clk = ~clk;

  cpu4_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_cf(alu_cf), .alu_sf(alu_sf), .alu_zf(alu_zf),
    .flags(flags), .pc(pc), .halted(halted), .reg_dump(reg_dump)
  );

  // Combinational ALU sitting beside the controller.
  logic [4:0] alu_sum;
  logic [7:0] alu_rot;
  always_comb begin
    alu_sum = 5'd0;
    alu_rot = 8'd0;
    alu_r   = 4'd0;
    alu_cf  = 1'b0;
    case (alu_op)
      2'b11: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r   = alu_sum[3:0];
        alu_cf  = alu_sum[4];
      end
      2'b00: begin
        alu_r  = alu_a - alu_b;
        alu_cf = (alu_a < alu_b);
      end
      2'b10: begin
        alu_rot = {alu_a, alu_a} << alu_b[1:0];
        alu_r   = alu_rot[7:4];
      end
      default: alu_r = 4'd0;
    endcase
    alu_sf = alu_r[3];
    alu_zf = (alu_r == 4'd0);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ins(input int op, input int rd, input int lo);
    return 10'((op << 7) | (rd << 5) | (lo & 15));
  endfunction

  function automatic logic [15:0] m_dump();
    return 16'((m_r[3] << 12) | (m_r[2] << 8) | (m_r[1] << 4) | m_r[0]);
  endfunction

  function automatic logic [2:0] m_flags();
    return 3'((m_cf << 2) | (m_sf << 1) | m_zf);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_pc = 0; m_cf = 0; m_sf = 0; m_zf = 0; m_halt = 0;
  endtask

  task automatic set_flags(input int res, input int cf);
    m_cf = cf;
    m_sf = (res >= 8) ? 1 : 0;
    m_zf = (res == 0) ? 1 : 0;
  endtask

  // One instruction at the architectural level.
  task automatic model_exec(input logic [9:0] w);
    int op, rd, rs, imm, a, b, res, n;
    op = int'(w[9:7]); rd = int'(w[6:5]); rs = int'(w[1:0]); imm = int'(w[3:0]);
    a = m_r[rd]; b = m_r[rs];
    case (op)
      1: m_r[rd] = imm;
      2: begin res = (a + b) % 16; set_flags(res, (a + b > 15) ? 1 : 0); m_r[rd] = res; end
      3: begin res = (a - b + 16) % 16; set_flags(res, (a < b) ? 1 : 0); end
      4: begin n = b % 4; res = ((a << n) | (a >> (4 - n))) % 16; set_flags(res, 0); m_r[rd] = res; end
      default: ;
    endcase
    if (op == 7) m_halt = 1;
    else if (op == 5 && m_zf == 1) m_pc = imm;
    else if (op == 6 && m_cf == 1) m_pc = imm;
    else m_pc = (m_pc + 1) % 16;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_req", 16'(imem_req), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_pc", 16'(pc), 16'd0);
    chk("rst_flags", 16'(flags), 16'd0);
    chk("rst_regs", reg_dump, 16'd0);
    chk("rst_aluop", 16'(alu_op), 16'd3);
    chk("rst_alua", 16'(alu_a), 16'd0);
    chk("rst_alub", 16'(alu_b), 16'd0);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    chk("boot_req", 16'(imem_req), 16'd0);
    @(negedge clk);
    chk("first_req", 16'(imem_req), 16'd1);
    chk("first_addr", 16'(imem_addr), 16'd0);
  endtask

  // Entered and left at a falling edge with the DUT in FETCH (or HALT).
  task automatic run_instr(input int waits);
    logic [9:0] w;
    int op, exp_op, exp_a, exp_b;
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      imem_data = 10'($urandom);
      chk("wait_req", 16'(imem_req), 16'd1);
      chk("wait_addr", 16'(imem_addr), 16'(m_pc));
      @(negedge clk);
    end
    w = mem[m_pc];
    imem_ack = 1'b1;
    imem_data = w;
    chk("fetch_req", 16'(imem_req), 16'd1);
    chk("fetch_addr", 16'(imem_addr), 16'(m_pc));
    @(negedge clk);
    imem_ack = 1'($urandom);
    imem_data = 10'($urandom);
    op = int'(w[9:7]);
    exp_op = 3; exp_a = 0; exp_b = 0;
    if (op >= 2 && op <= 4) begin
      exp_op = (op == 2) ? 3 : (op == 3) ? 0 : 2;
      exp_a = m_r[w[6:5]];
      exp_b = m_r[w[1:0]];
    end
    chk("exec_req", 16'(imem_req), 16'd0);
    chk("exec_aluop", 16'(alu_op), 16'(exp_op));
    chk("exec_alua", 16'(alu_a), 16'(exp_a));
    chk("exec_alub", 16'(alu_b), 16'(exp_b));
    @(negedge clk);
    imem_ack = 1'b0;
    model_exec(w);
    chk("commit_pc", 16'(pc), 16'(m_pc));
    chk("commit_flags", 16'(flags), 16'(m_flags()));
    chk("commit_regs", reg_dump, m_dump());
    chk("commit_halted", 16'(halted), 16'(m_halt));
    chk("commit_req", 16'(imem_req), 16'(!m_halt));
  endtask

  task automatic run_prog(input int n);
    for (int i = 0; i < n && !m_halt; i++) run_instr($urandom_range(0, 2));
    if (m_halt) begin
      for (int i = 0; i < 3; i++) begin
        imem_ack = 1'b1;
        @(negedge clk);
        chk("halt_req", 16'(imem_req), 16'd0);
        chk("halt_flag", 16'(halted), 16'd1);
        chk("halt_pc", 16'(pc), 16'(m_pc));
      end
      imem_ack = 1'b0;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 10'd0;
  endtask

  initial begin
    clear_mem();
    do_reset();

    // LDI R0,3; LDI R1,5; ADD R0,R1 with zero-wait memory
    mem[0] = ins(1, 0, 3); mem[1] = ins(1, 1, 5); mem[2] = ins(2, 0, 1);
    for (int i = 0; i < 3; i++) run_instr(0);
    chk("p1_r0", 16'(reg_dump[3:0]), 16'd8);
    chk("p1_flags", 16'(flags), 16'b010);
    chk("p1_pc", 16'(pc), 16'd3);

    // CMP of equal registers then JZ
    clear_mem(); do_reset();
    mem[0] = ins(1, 2, 4); mem[1] = ins(1, 3, 4); mem[2] = ins(3, 2, 3); mem[3] = ins(5, 0, 10);
    for (int i = 0; i < 4; i++) run_instr(0);
    chk("p2_pc", 16'(pc), 16'd10);
    chk("p2_zf", 16'(flags[0]), 16'd1);
    chk("p2_r2", 16'(reg_dump[11:8]), 16'd4);

    // carry out of ADD, JC taken, then ROL clears CF
    clear_mem(); do_reset();
    mem[0] = ins(1, 0, 15); mem[1] = ins(1, 1, 1); mem[2] = ins(2, 0, 1);
    mem[3] = ins(6, 0, 7); mem[7] = ins(4, 0, 1);
    for (int i = 0; i < 4; i++) run_instr(0);
    chk("p3_r0", 16'(reg_dump[3:0]), 16'd0);
    chk("p3_flags", 16'(flags), 16'b101);
    chk("p3_pc", 16'(pc), 16'd7);
    run_instr(0);
    chk("p3_rol_cf", 16'(flags[2]), 16'd0);

    // three wait states on a fetch
    clear_mem(); do_reset();
    mem[0] = ins(1, 1, 9);
    run_instr(3);
    chk("p4_r1", 16'(reg_dump[7:4]), 16'd9);

    // PC wrap through NOPs, then HLT at address 15
    clear_mem(); do_reset();
    mem[0] = ins(3, 0, 0); mem[1] = ins(5, 0, 13);
    for (int i = 0; i < 5; i++) run_instr(1);
    chk("p5_wrap_pc", 16'(pc), 16'd0);
    mem[0] = ins(5, 0, 15); mem[15] = ins(7, 0, 0);
    run_prog(4);
    chk("p5_halted", 16'(halted), 16'd1);
    chk("p5_pc", 16'(pc), 16'd15);

    // reset in the middle of an ADD's EXEC cycle
    clear_mem(); do_reset();
    mem[0] = ins(1, 1, 5); mem[1] = ins(2, 0, 1);
    run_instr(0);
    imem_ack = 1'b1;
    imem_data = mem[1];
    @(negedge clk);
    chk("p6_in_exec", 16'(alu_op), 16'd3);
    rst_n = 1'b0;
    #1;
    chk("p6_regs", reg_dump, 16'd0);
    chk("p6_flags", 16'(flags), 16'd0);
    chk("p6_pc", 16'(pc), 16'd0);
    chk("p6_req", 16'(imem_req), 16'd0);
    @(negedge clk);
    chk("p6_hold_regs", reg_dump, 16'd0);

    // random programs with random wait states
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) mem[i] = 10'($urandom);
      do_reset();
      run_prog(40);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
